// File: rtl/traffic_pkg.sv
// rtl/traffic_pkg.sv - shared phase encoding, lamp codes and phase ordering
// Purpose: phase_e enum, lamp constants {R,Y,G}, digit width, next-phase helper.
// Config: TRAFFIC_NIGHT_EN adds the NIGHT phase (encoding 6).
package traffic_pkg;

    localparam int         DIGIT_W = 4;
    localparam logic [2:0] LT_RED  = 3'b100;
    localparam logic [2:0] LT_YEL  = 3'b010;
    localparam logic [2:0] LT_GRN  = 3'b001;
    localparam logic [2:0] LT_OFF  = 3'b000;

    typedef enum logic [2:0] {
        A_GRN  = 3'd0,
        A_YEL  = 3'd1,
        CLR_AB = 3'd2,
        B_GRN  = 3'd3,
        B_YEL  = 3'd4,
        CLR_BA = 3'd5
`ifdef TRAFFIC_NIGHT_EN
        , NIGHT = 3'd6
`endif
    } phase_e;

    // Fixed ring order; NIGHT is left through its own path and never via this helper.
    function automatic phase_e next_phase(input phase_e p);
        case (p)
            A_GRN:   return A_YEL;
            A_YEL:   return CLR_AB;
            CLR_AB:  return B_GRN;
            B_GRN:   return B_YEL;
            B_YEL:   return CLR_BA;
            CLR_BA:  return A_GRN;
            default: return CLR_BA;
        endcase
    endfunction

endpackage

// File: rtl/traffic_phase_ctrl_if.sv
// rtl/traffic_phase_ctrl_if.sv - operator inputs and lamp/digit outputs of the controller
// Ports: manual_i, step_i, [night_i] (to controller); light_A/B, l_7_A/B, phase_o (from controller).
// Config: night_i exists only with TRAFFIC_NIGHT_EN.
interface traffic_phase_ctrl_if;
    import traffic_pkg::*;

    logic               manual_i;
    logic               step_i;
`ifdef TRAFFIC_NIGHT_EN
    logic               night_i;
`endif
    logic [2:0]         light_A;
    logic [2:0]         light_B;
    logic [DIGIT_W-1:0] l_7_A;
    logic [DIGIT_W-1:0] l_7_B;
    logic [2:0]         phase_o;

    modport master (
`ifdef TRAFFIC_NIGHT_EN
        output night_i,
`endif
        output manual_i, step_i,
        input  light_A, light_B, l_7_A, l_7_B, phase_o
    );

    modport slave (
`ifdef TRAFFIC_NIGHT_EN
        input  night_i,
`endif
        input  manual_i, step_i,
        output light_A, light_B, l_7_A, l_7_B, phase_o
    );

endinterface

// File: rtl/traffic_phase_ctrl_prescaler.sv
// rtl/traffic_phase_ctrl_prescaler.sv - divides clk down to a one-cycle tick every TICK_DIV cycles
// Ports: clk, rst_n (sync, active-low), hold_i (park count at 0, no tick), tick_o.
module tick_prescaler #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic hold_i,
    output logic tick_o
);

    localparam int          CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] pre_q, pre_d;

    always_comb begin
        tick_o = !hold_i && (pre_q == LAST);
        if (hold_i || tick_o) begin
            pre_d = '0;
        end else begin
            pre_d = pre_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_d;
        end
    end

endmodule

// File: rtl/traffic_phase_ctrl.sv
// rtl/traffic_phase_ctrl.sv - two-direction intersection phase sequencer with countdown digits
// Ports: clk, rst_n (sync, active-low), bus (traffic_phase_ctrl_if.slave):
//   manual_i/step_i operator control, light_A/B {R,Y,G}, l_7_A/B digits, phase_o status.
// Config: TRAFFIC_NIGHT_EN adds night_i and the flashing-yellow NIGHT phase.
module traffic_phase_ctrl
    import traffic_pkg::*;
#(
    parameter int TICK_DIV = 50_000_000,
    parameter int GREEN_T  = 5,
    parameter int YELLOW_T = 2,
    parameter int ALLRED_T = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    traffic_phase_ctrl_if.slave  bus
);

    // Each side's red countdown must fit one decimal digit.
    if (GREEN_T + YELLOW_T + 2 * ALLRED_T > 9 || GREEN_T < 1 || YELLOW_T < 1 || ALLRED_T < 1) begin : g_bad_timing
        $error("traffic_phase_ctrl: durations must be >=1 and GREEN_T+YELLOW_T+2*ALLRED_T <= 9");
    end

    localparam logic [DIGIT_W-1:0] G4 = DIGIT_W'(GREEN_T);
    localparam logic [DIGIT_W-1:0] Y4 = DIGIT_W'(YELLOW_T);
    localparam logic [DIGIT_W-1:0] R4 = DIGIT_W'(ALLRED_T);
    localparam logic [DIGIT_W-1:0] B_RST = DIGIT_W'(2 * ALLRED_T + GREEN_T + YELLOW_T);

    function automatic logic [DIGIT_W-1:0] dur(input phase_e p);
        case (p)
            A_GRN, B_GRN: return G4;
            A_YEL, B_YEL: return Y4;
            default:      return R4;
        endcase
    endfunction

    phase_e               phase_q, phase_d;
    logic [DIGIT_W-1:0]   cnt_q, cnt_d;
    logic                 manual_q, manual_d;
    logic [2:0]           light_a_q, light_a_d, light_b_q, light_b_d;
    logic [DIGIT_W-1:0]   l7_a_q, l7_a_d, l7_b_q, l7_b_d;
    logic                 tick;
    logic                 hold;
`ifdef TRAFFIC_NIGHT_EN
    logic                 blink_q, blink_d;
    assign hold = bus.manual_i && !bus.night_i;
`else
    assign hold = bus.manual_i;
`endif

    tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
        .clk    (clk),
        .rst_n  (rst_n),
        .hold_i (hold),
        .tick_o (tick)
    );

    always_comb begin
        phase_d  = phase_q;
        cnt_d    = cnt_q;
        manual_d = bus.manual_i;
`ifdef TRAFFIC_NIGHT_EN
        blink_d  = blink_q;
        if (bus.night_i) begin
            if (phase_q != NIGHT) begin
                phase_d = NIGHT;
                blink_d = 1'b1;
            end else if (tick) begin
                blink_d = ~blink_q;
            end
        end else if (phase_q == NIGHT) begin
            phase_d = CLR_BA;
            cnt_d   = R4;
        end else
`endif
        if (bus.manual_i) begin
            if (bus.step_i) begin
                phase_d = next_phase(phase_q);
                cnt_d   = dur(phase_d);
            end
        end else if (manual_q) begin
            // First auto cycle after manual: restart the current phase in full.
            cnt_d = dur(phase_q);
        end else if (tick) begin
            if (cnt_q == DIGIT_W'(1)) begin
                phase_d = next_phase(phase_q);
                cnt_d   = dur(phase_d);
            end else begin
                cnt_d = cnt_q - DIGIT_W'(1);
            end
        end

        // Lamps follow the next phase so they change on the same edge as phase_q.
        light_a_d = LT_RED;
        light_b_d = LT_RED;
        case (phase_d)
            A_GRN: light_a_d = LT_GRN;
            A_YEL: light_a_d = LT_YEL;
            B_GRN: light_b_d = LT_GRN;
            B_YEL: light_b_d = LT_YEL;
`ifdef TRAFFIC_NIGHT_EN
            NIGHT: begin
                light_a_d = blink_d ? LT_YEL : LT_OFF;
                light_b_d = blink_d ? LT_YEL : LT_OFF;
            end
`endif
            default: ;
        endcase

        // Red side counts through every phase before its own green.
        l7_a_d = '0;
        l7_b_d = '0;
        if (!bus.manual_i) begin
            case (phase_q)
                A_GRN:  begin l7_a_d = cnt_q + Y4;           l7_b_d = cnt_q + Y4 + R4;      end
                A_YEL:  begin l7_a_d = cnt_q;                l7_b_d = cnt_q + R4;           end
                CLR_AB: begin l7_a_d = cnt_q + G4 + Y4 + R4; l7_b_d = cnt_q;                end
                B_GRN:  begin l7_a_d = cnt_q + Y4 + R4;      l7_b_d = cnt_q + Y4;           end
                B_YEL:  begin l7_a_d = cnt_q + R4;           l7_b_d = cnt_q;                end
                CLR_BA: begin l7_a_d = cnt_q;                l7_b_d = cnt_q + G4 + Y4 + R4; end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            phase_q   <= CLR_BA;
            cnt_q     <= R4;
            manual_q  <= 1'b0;
            light_a_q <= LT_RED;
            light_b_q <= LT_RED;
            l7_a_q    <= R4;
            l7_b_q    <= B_RST;
`ifdef TRAFFIC_NIGHT_EN
            blink_q   <= 1'b0;
`endif
        end else begin
            phase_q   <= phase_d;
            cnt_q     <= cnt_d;
            manual_q  <= manual_d;
            light_a_q <= light_a_d;
            light_b_q <= light_b_d;
            l7_a_q    <= l7_a_d;
            l7_b_q    <= l7_b_d;
`ifdef TRAFFIC_NIGHT_EN
            blink_q   <= blink_d;
`endif
        end
    end

    assign bus.light_A = light_a_q;
    assign bus.light_B = light_b_q;
    assign bus.l_7_A   = l7_a_q;
    assign bus.l_7_B   = l7_b_q;
    assign bus.phase_o = phase_q;

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// tb/tb_traffic_phase_ctrl.sv - directed self-checking bench for traffic_phase_ctrl (TICK_DIV=4)
module tb_traffic_phase_ctrl;
    import traffic_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    traffic_phase_ctrl_if bus ();

    traffic_phase_ctrl #(.TICK_DIV(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clk_n(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_phase(input string tag, input phase_e ph);
        check({tag, ".phase"}, 32'(bus.phase_o), 32'(ph));
    endtask

    task automatic chk_lamps(input string tag, input logic [2:0] la, input logic [2:0] lb);
        check({tag, ".light_A"}, 32'(bus.light_A), 32'(la));
        check({tag, ".light_B"}, 32'(bus.light_B), 32'(lb));
    endtask

    task automatic chk_digits(input string tag, input logic [3:0] da, input logic [3:0] db);
        check({tag, ".l_7_A"}, 32'(bus.l_7_A), 32'(da));
        check({tag, ".l_7_B"}, 32'(bus.l_7_B), 32'(db));
    endtask

    initial begin
        bus.manual_i = 1'b0;
        bus.step_i   = 1'b0;
`ifdef TRAFFIC_NIGHT_EN
        bus.night_i  = 1'b0;
`endif
        rst_n = 1'b0;
        clk_n(2);
        rst_n = 1'b1;

        // Reset release, first tick, then free run through the ring.
        clk_n(1);
        chk_phase("rst", CLR_BA);  chk_lamps("rst", LT_RED, LT_RED);  chk_digits("rst", 4'd1, 4'd9);
        clk_n(2);  chk_phase("pre_tick1", CLR_BA);
        clk_n(1);  chk_phase("tick1", A_GRN);  chk_lamps("tick1", LT_GRN, LT_RED);
        chk_digits("tick1_lag", 4'd1, 4'd9);
        clk_n(1);  chk_digits("a_grn", 4'd7, 4'd8);
        bus.step_i = 1'b1;                      // must be ignored in auto mode
        clk_n(1);
        bus.step_i = 1'b0;
        chk_phase("step_auto", A_GRN);
        clk_n(17); chk_phase("a_grn_end", A_GRN);
        clk_n(1);  chk_phase("a_yel", A_YEL);  chk_lamps("a_yel", LT_YEL, LT_RED);
        clk_n(1);  chk_digits("a_yel", 4'd2, 4'd3);
        clk_n(6);  chk_phase("a_yel_end", A_YEL);
        clk_n(1);  chk_phase("clr_ab", CLR_AB);  chk_lamps("clr_ab", LT_RED, LT_RED);
        clk_n(1);  chk_digits("clr_ab", 4'd9, 4'd1);
        clk_n(3);  chk_phase("b_grn", B_GRN);  chk_lamps("b_grn", LT_RED, LT_GRN);
        clk_n(1);  chk_digits("b_grn", 4'd8, 4'd7);

        // Manual freeze mid A_GRN, then restart with full duration.
        rst_n = 1'b0;  clk_n(1);  rst_n = 1'b1;
        clk_n(13);
        bus.manual_i = 1'b1;
        clk_n(20);
        chk_phase("man_hold", A_GRN);  chk_lamps("man_hold", LT_GRN, LT_RED);
        chk_digits("man_hold", 4'd0, 4'd0);
        bus.manual_i = 1'b0;
        clk_n(2);  chk_digits("man_exit", 4'd7, 4'd8);
        clk_n(17); chk_phase("man_exit_end", A_GRN);
        clk_n(1);  chk_phase("man_exit_adv", A_YEL);

        bus.manual_i = 1'b1;
        clk_n(20);
        chk_phase("man_yel", A_YEL);
        bus.step_i = 1'b1;  clk_n(1);  bus.step_i = 1'b0;
        chk_phase("man_step", CLR_AB);  chk_lamps("man_step", LT_RED, LT_RED);
        clk_n(3);
        chk_phase("man_step_hold", CLR_AB);  chk_digits("man_step_hold", 4'd0, 4'd0);

        // Step lands on the cycle a tick was due: one advance only.
        bus.manual_i = 1'b0;
        clk_n(3);
        bus.manual_i = 1'b1;  bus.step_i = 1'b1;
        clk_n(1);
        bus.step_i = 1'b0;
        chk_phase("step_tick", B_GRN);
        clk_n(2);  chk_phase("step_tick_hold", B_GRN);

        // Reset during B_YEL; prescaler restarts at 0.
        bus.step_i = 1'b1;  clk_n(1);  bus.step_i = 1'b0;
        chk_phase("b_yel", B_YEL);  chk_lamps("b_yel", LT_RED, LT_YEL);
        bus.manual_i = 1'b0;
        clk_n(2);
        rst_n = 1'b0;  clk_n(1);  rst_n = 1'b1;
        chk_phase("rst_mid", CLR_BA);  chk_lamps("rst_mid", LT_RED, LT_RED);
        chk_digits("rst_mid", 4'd1, 4'd9);
        clk_n(3);  chk_phase("rst_mid_pre", CLR_BA);
        clk_n(1);  chk_phase("rst_mid_tick", A_GRN);

`ifdef TRAFFIC_NIGHT_EN
        begin
            bit seen;
            bus.night_i = 1'b1;
            clk_n(1);
            check("night.phase", 32'(bus.phase_o), 32'd6);
            chk_lamps("night_on", LT_YEL, LT_YEL);
            seen = 1'b0;
            for (int i = 0; i < 6 && !seen; i++) begin
                clk_n(1);
                if (bus.light_A == LT_OFF) seen = 1'b1;
            end
            check("night_off_seen", 32'(seen), 32'd1);
            chk_lamps("night_off", LT_OFF, LT_OFF);
            bus.night_i = 1'b0;
            clk_n(1);
            chk_phase("night_exit", CLR_BA);  chk_lamps("night_exit", LT_RED, LT_RED);
            seen = 1'b0;
            for (int i = 0; i < 8 && !seen; i++) begin
                clk_n(1);
                if (bus.phase_o == 3'(A_GRN)) seen = 1'b1;
            end
            check("night_to_a_grn", 32'(seen), 32'd1);
        end
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
